axis_counter_chk: RTL and testbench
===================================

Name: axis_counter_chk

Overview:
AXI4-Stream sink that consumes frames from the counter-pattern source, checks every beat against the expected pattern, and reports pass/fail statistics. Expected per-frame data is {frame_id[15:0], beat[15:0]}, with TLAST on beat FRAME_BEATS-1. It also generates optional pseudo-random TREADY backpressure and measures inter-frame idle gaps. It sits at the far end of the FIFO under test in the simulation bench.

Parameters:
DATA_W, 32, TDATA width; expected word is zero-extended or truncated to DATA_W.
KEEP_W, DATA_W/8, TKEEP width.
USER_W, 1, TUSER width; accepted, not checked.
FRAME_BEATS, 8, beats per frame (>=1).
LFSR_SEED, 16'hACE1, non-zero reset seed of the backpressure LFSR.

Ports:
aclk  in  1  clock; all logic is on the rising edge.
areset  in  1  asynchronous, active-high reset.
s_axis_tvalid  in  1  stream valid.
s_axis_tready  out  1  stream ready, registered.
s_axis_tdata  in  DATA_W  stream data.
s_axis_tkeep  in  KEEP_W  byte enables; all ones expected.
s_axis_tlast  in  1  end of frame.
s_axis_tuser  in  USER_W  ignored.
bp_enable  in  1  1 = LFSR-driven backpressure, 0 = always ready.
clear  in  1  synchronous clear of checker state and statistics.
frames_ok  out  32  count of error-free frames; wraps.
err_count  out  16  count of beats with at least one error; saturates at 16'hFFFF.
err_flags  out  4  sticky flags: [0] data mismatch, [1] early TLAST, [2] missing TLAST, [3] TKEEP not all ones.
frame_done  out  1  one-cycle pulse, the cycle after the last beat of a frame is accepted.
frame_pass  out  1  valid with frame_done; 1 = the frame had no errors.
last_gap  out  16  idle cycles between the previous frame's last beat and this frame's first accepted beat; saturates.

Behaviour:
- Reset values (async assert): s_axis_tready=0, frames_ok=0, err_count=0, err_flags=0, frame_done=0, frame_pass=0, last_gap=0, exp_beat=0, exp_frame=0, LFSR=LFSR_SEED, frame_err=0, gap_cnt=0. Deassertion is consumed synchronously; tready first rises 1 cycle after reset release.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle while bp_enable=1 and holds otherwise. tready <= ~bp_enable | lfsr_next[0].
- Handshake: a beat is accepted when tvalid & tready. No other state changes depend on tdata.
- Per accepted beat, the expected word is exp = {exp_frame[15:0], exp_beat[15:0]} sized to DATA_W. Checks:
  - data_err = (tdata != exp)
  - keep_err = (tkeep != all ones)
  - early = tlast & (exp_beat != FRAME_BEATS-1)
  - missing = ~tlast & (exp_beat == FRAME_BEATS-1)
- Any error on a beat: err_count +1 (saturating), the corresponding err_flags bits are set, and frame_err is set.
- End of frame: a beat with tlast, or a beat with exp_beat == FRAME_BEATS-1.
  - On that beat: exp_beat <= 0, exp_frame <= exp_frame+1 (wraps at 16 bits).
  - Next cycle: frame_done=1 and frame_pass = ~(frame_err | this beat's errors).
  - If the frame passed, frames_ok +1. frame_err is then cleared.
- Not end of frame: exp_beat +1. There is no resynchronisation to received data; a mismatch persists until the pattern realigns.
- FRAME_BEATS=1: every beat is end of frame; missing TLAST is flagged if tlast=0.
- Gap counter:
  - Cleared on each end-of-frame beat, then increments every cycle (saturating at 16'hFFFF).
  - On the first accepted beat of the next frame (exp_beat==0), last_gap <= gap_cnt.
  - The first frame after reset or clear reports the count since reset or clear.
- clear=1 resets everything except the LFSR and tready to its reset value. Clear has priority over a simultaneous handshake: that beat is accepted on the bus but not checked or counted.
- Reset mid-frame: all state is lost; the next accepted beat is checked as beat 0 of frame 0.

Test Plan:
- Source with FRAME_BEATS=8 and bp_enable=0 for 4 frames -> frames_ok=4, err_count=0, err_flags=0, 4 frame_done pulses with frame_pass=1, last_gap=17 for frames 2..4 (16 wait cycles plus the reload cycle).
- bp_enable=1 for 100 frames -> tready toggles per LFSR, frames_ok=100, err_count=0, exp_frame=100.
- Corrupt frame 2 beat 3 data (XOR 1) -> err_flags=4'b0001, err_count=1, frame 2 frame_pass=0, frames_ok = total minus 1, frame 3 passes.
- TLAST on beat 5 of frame 0 -> err_flags[1]=1, frame_done after beat 5; next beat 0x0001_0000 passes. TLAST dropped on beat 7 -> err_flags[2]=1, the frame still ends.
- tkeep=4'b0111 on one beat -> err_flags[3]=1, err_count=1. 70000 erroneous beats -> err_count holds at 16'hFFFF.
- areset asserted mid-frame at beat 4, then the source is restarted -> tready=0 during reset, all outputs 0. clear coincident with a handshake -> that beat is not counted and the stats read 0 next cycle.

Source files
------------

// File: rtl/axis_counter_chk_if.sv
// axis_counter_chk_if: AXI4-Stream bundle between the counter-pattern source and the checker.
// Signals: tvalid/tready handshake, tdata (DATA_W), tkeep (KEEP_W), tlast, tuser (USER_W).
// Modports: master drives the payload and samples tready; slave samples the payload and drives tready.
interface axis_counter_chk_if #(
   parameter int DATA_W = 32,
   parameter int KEEP_W = DATA_W / 8,
   parameter int USER_W = 1
) ();
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic              tlast;
   logic [USER_W-1:0] tuser;
   modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/axis_counter_chk.sv
// axis_counter_chk: AXI4-Stream sink that checks {frame_id, beat} counter frames and keeps statistics.
// Ports:
//   aclk, areset           clock, asynchronous active-high reset
//   s_axis (slave)         checked stream; tready is registered and optionally LFSR-throttled
//   bp_enable              1 = pseudo-random backpressure, 0 = always ready
//   clear                  synchronous clear of checker state and statistics
//   frames_ok              error-free frame count (wraps)
//   err_count              beats with any error (saturates)
//   err_flags              sticky {keep, missing tlast, early tlast, data}
//   frame_done/frame_pass  one-cycle end-of-frame pulse and its verdict
//   last_gap               idle cycles before the current frame's first beat (saturates)
module axis_counter_chk #(
   parameter int          DATA_W      = 32,
   parameter int          KEEP_W      = DATA_W / 8,
   parameter int          USER_W      = 1,
   parameter int          FRAME_BEATS = 8,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                aclk,
   input  logic                areset,
   axis_counter_chk_if.slave   s_axis,
   input  logic                bp_enable,
   input  logic                clear,
   output logic [31:0]         frames_ok,
   output logic [15:0]         err_count,
   output logic [3:0]          err_flags,
   output logic                frame_done,
   output logic                frame_pass,
   output logic [15:0]         last_gap
);
   localparam logic [15:0] LAST_BEAT = 16'(FRAME_BEATS - 1);
   logic [15:0]       lfsr, lfsr_next;
   logic [15:0]       exp_beat, exp_frame, gap_cnt;
   logic              frame_err;
   logic              acc, at_last, eof, beat_err, frame_good;
   logic [DATA_W-1:0] exp_word;
   logic [3:0]        beat_errs;
   logic              unused_tuser;
   assign unused_tuser = ^s_axis.tuser;
   always_comb begin
      lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      acc        = s_axis.tvalid & s_axis.tready;
      at_last    = exp_beat == LAST_BEAT;
      exp_word   = DATA_W'({exp_frame, exp_beat});
      beat_errs  = acc ? {~&s_axis.tkeep, ~s_axis.tlast & at_last, s_axis.tlast & ~at_last,
                          s_axis.tdata != exp_word} : 4'd0;
      beat_err   = |beat_errs;
      eof        = acc & (s_axis.tlast | at_last);
      frame_good = eof & ~(frame_err | beat_err);
   end
   // Backpressure generator runs independently of clear so the ready pattern is never disturbed.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         lfsr          <= LFSR_SEED;
         s_axis.tready <= 1'b0;
      end else begin
         if (bp_enable) lfsr <= lfsr_next;
         s_axis.tready <= ~bp_enable | lfsr_next[0];
      end
   end
   // Clear outranks a coincident handshake: that beat is dropped unchecked.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         frames_ok  <= '0;
         err_count  <= '0;
         err_flags  <= '0;
         frame_done <= 1'b0;
         frame_pass <= 1'b0;
         last_gap   <= '0;
         exp_beat   <= '0;
         exp_frame  <= '0;
         frame_err  <= 1'b0;
         gap_cnt    <= '0;
      end else if (clear) begin
         frames_ok  <= '0;
         err_count  <= '0;
         err_flags  <= '0;
         frame_done <= 1'b0;
         frame_pass <= 1'b0;
         last_gap   <= '0;
         exp_beat   <= '0;
         exp_frame  <= '0;
         frame_err  <= 1'b0;
         gap_cnt    <= '0;
      end else begin
         frame_done <= eof;
         frame_pass <= frame_good;
         frames_ok  <= frames_ok + 32'(frame_good);
         gap_cnt    <= eof ? 16'd0 : gap_cnt + 16'(~&gap_cnt);
         if (beat_err) begin
            err_count <= err_count + 16'(~&err_count);
            err_flags <= err_flags | beat_errs;
         end
         if (acc) begin
            if (exp_beat == 16'd0) last_gap <= gap_cnt;
            exp_beat  <= eof ? 16'd0 : exp_beat + 16'd1;
            exp_frame <= exp_frame + 16'(eof);
            frame_err <= ~eof & (frame_err | beat_err);
         end
      end
   end
endmodule

// File: tb/tb_axis_counter_chk.sv
// tb_axis_counter_chk: directed scoreboard bench for axis_counter_chk.
module tb_axis_counter_chk;
   localparam int FB = 8;
   typedef struct {
      logic pass;
      int   gap;
      bit   chk;
   } exp_t;
   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        bp_enable = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] frames_ok;
   logic [15:0] err_count;
   logic [3:0]  err_flags;
   logic        frame_done, frame_pass;
   logic [15:0] last_gap;
   int          tests = 0;
   int          fails = 0;
   exp_t        sb[$];
   exp_t        mon_e;
   bit          sb_on = 1'b1;
   int          done_cnt = 0;
   int          e_done = 0;
   int          e_err = 0;
   int          e_frames_ok = 0;
   logic [3:0]  e_flags = 4'd0;
   logic [15:0] m_lfsr;
   logic        m_rdy;
   bit          rdy_low_seen = 1'b0;
   axis_counter_chk_if #(.DATA_W(32)) s_axis ();
   axis_counter_chk #(.DATA_W(32), .FRAME_BEATS(FB)) dut (
      .aclk(aclk), .areset(areset), .s_axis(s_axis), .bp_enable(bp_enable), .clear(clear),
      .frames_ok(frames_ok), .err_count(err_count), .err_flags(err_flags),
      .frame_done(frame_done), .frame_pass(frame_pass), .last_gap(last_gap)
   );
   always #5 aclk = ~aclk;
   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   always @(posedge aclk or posedge areset) begin
      if (areset) begin
         m_lfsr <= 16'hACE1;
         m_rdy  <= 1'b0;
      end else begin
         if (bp_enable) m_lfsr <= lfsr_step(m_lfsr);
         m_rdy <= ~bp_enable | lfsr_step(m_lfsr)[0];
      end
   end
   always @(negedge aclk) begin
      chk("tready_model", {31'd0, s_axis.tready}, {31'd0, m_rdy});
      if (bp_enable && !s_axis.tready) rdy_low_seen = 1'b1;
      if (frame_done) begin
         done_cnt++;
         if (sb_on) begin
            chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
               mon_e = sb.pop_front();
               chk("frame_pass", {31'd0, frame_pass}, {31'd0, mon_e.pass});
               if (mon_e.chk) chk("last_gap", {16'd0, last_gap}, mon_e.gap);
            end
         end
      end
   end
   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n = 0;
      @(negedge aclk);
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = d;
      s_axis.tkeep  = k;
      s_axis.tlast  = l;
      while (!s_axis.tready && n < 200) begin
         @(negedge aclk);
         n++;
      end
      chk("handshake_timeout", {31'd0, n < 200}, 32'd1);
      @(posedge aclk);
      #1;
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
   endtask
   task automatic send_frame(input int fid, input int idle, input bit chk_gap, input int bad_beat = -1,
                             input int early_at = -1, input bit drop_last = 1'b0, input int keep_beat = -1);
      int          nb = (early_at >= 0) ? early_at + 1 : FB;
      logic        fp = 1'b1;
      logic [3:0]  f;
      logic [31:0] d;
      repeat (idle) @(negedge aclk);
      for (int b = 0; b < nb; b++) begin
         d = {fid[15:0], b[15:0]};
         f = 4'd0;
         if (b == bad_beat) begin
            d = d ^ 32'd1;
            f[0] = 1'b1;
         end
         if (b == early_at && b != FB - 1) f[1] = 1'b1;
         if (b == FB - 1 && drop_last) f[2] = 1'b1;
         if (b == keep_beat) f[3] = 1'b1;
         if (f != 4'd0) begin
            fp = 1'b0;
            e_err++;
            e_flags = e_flags | f;
         end
         if (b == nb - 1) sb.push_back('{fp, idle, chk_gap});
         send_beat(d, (b == keep_beat) ? 4'b0111 : 4'hF, (b == nb - 1) && !drop_last);
      end
      e_frames_ok += int'(fp);
      e_done++;
   endtask
   task automatic zero_model();
      e_err = 0;
      e_frames_ok = 0;
      e_flags = 4'd0;
      e_done = 0;
      done_cnt = 0;
   endtask
   task automatic do_clear();
      @(negedge aclk);
      clear = 1'b1;
      @(negedge aclk);
      clear = 1'b0;
      zero_model();
   endtask
   task automatic check_stats(input string tag);
      repeat (2) @(negedge aclk);
      chk({tag, "_frames_ok"}, frames_ok, e_frames_ok);
      chk({tag, "_err_count"}, {16'd0, err_count}, e_err);
      chk({tag, "_err_flags"}, {28'd0, err_flags}, {28'd0, e_flags});
      chk({tag, "_done_pulses"}, done_cnt, e_done);
      chk({tag, "_sb_drained"}, sb.size(), 32'd0);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before the bench completed");
      $fatal(1, "watchdog");
   end
   initial begin
      s_axis.tvalid = 1'b0;
      s_axis.tdata  = '0;
      s_axis.tkeep  = 4'hF;
      s_axis.tlast  = 1'b0;
      s_axis.tuser  = '0;
      repeat (3) @(negedge aclk);
      chk("rst_tready", {31'd0, s_axis.tready}, 32'd0);
      chk("rst_frames_ok", frames_ok, 32'd0);
      chk("rst_err_count", {16'd0, err_count}, 32'd0);
      chk("rst_err_flags", {28'd0, err_flags}, 32'd0);
      chk("rst_frame_done", {30'd0, frame_done, frame_pass}, 32'd0);
      chk("rst_last_gap", {16'd0, last_gap}, 32'd0);
      areset = 1'b0;
      @(negedge aclk);
      chk("tready_after_release", {31'd0, s_axis.tready}, 32'd1);
      // clean frames, fixed 17-cycle gaps
      send_frame(0, 0, 1'b0);
      for (int f = 1; f < 4; f++) send_frame(f, 17, 1'b1);
      check_stats("clean");
      // data corruption on frame 2 beat 3
      do_clear();
      send_frame(0, 0, 1'b0);
      send_frame(1, 2, 1'b1);
      send_frame(2, 2, 1'b1, 3);
      send_frame(3, 2, 1'b1);
      check_stats("corrupt");
      // early tlast on beat 5, then a normal frame 1
      do_clear();
      send_frame(0, 0, 1'b0, -1, 5);
      send_frame(1, 17, 1'b1);
      check_stats("early");
      // tlast dropped on the final beat
      do_clear();
      send_frame(0, 0, 1'b0, -1, -1, 1'b1);
      send_frame(1, 4, 1'b1);
      check_stats("missing");
      // short keep on one beat
      do_clear();
      send_frame(0, 0, 1'b0, -1, -1, 1'b0, 2);
      send_frame(1, 1, 1'b1);
      check_stats("keep");
      // LFSR backpressure over 100 frames, then one frame without it
      do_clear();
      bp_enable = 1'b1;
      for (int f = 0; f < 100; f++) send_frame(f, 0, 1'b0);
      @(negedge aclk);
      bp_enable = 1'b0;
      chk("bp_ready_low_seen", {31'd0, rdy_low_seen}, 32'd1);
      send_frame(100, 3, 1'b0);
      check_stats("backpressure");
      // error counter saturation
      do_clear();
      sb_on = 1'b0;
      @(negedge aclk);
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = '0;
      s_axis.tkeep  = 4'h0;
      s_axis.tlast  = 1'b0;
      repeat (65600) @(negedge aclk);
      s_axis.tvalid = 1'b0;
      s_axis.tkeep  = 4'hF;
      repeat (2) @(negedge aclk);
      chk("sat_err_count", {16'd0, err_count}, 32'h0000_FFFF);
      chk("sat_err_flags", {28'd0, err_flags}, 32'b1101);
      chk("sat_frames_ok", frames_ok, 32'd0);
      do_clear();
      sb_on = 1'b1;
      // reset in the middle of frame 1
      send_frame(0, 0, 1'b0);
      check_stats("pre_reset");
      for (int b = 0; b < 4; b++) send_beat({16'd1, b[15:0]}, 4'hF, 1'b0);
      @(negedge aclk);
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = {16'd1, 16'd4};
      areset = 1'b1;
      @(negedge aclk);
      chk("midrst_tready", {31'd0, s_axis.tready}, 32'd0);
      chk("midrst_frames_ok", frames_ok, 32'd0);
      chk("midrst_done", {28'd0, err_flags, frame_done, frame_pass} == 0, 32'd1);
      chk("midrst_err_count", {16'd0, err_count}, 32'd0);
      s_axis.tvalid = 1'b0;
      areset = 1'b0;
      zero_model();
      send_frame(0, 2, 1'b0);
      check_stats("post_reset");
      // clear coincident with a bad end-of-frame beat
      @(negedge aclk);
      clear = 1'b1;
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = 32'hDEAD_BEEF;
      s_axis.tkeep  = 4'h0;
      s_axis.tlast  = 1'b1;
      @(negedge aclk);
      chk("clr_hs_frames_ok", frames_ok, 32'd0);
      chk("clr_hs_err_count", {16'd0, err_count}, 32'd0);
      chk("clr_hs_err_flags", {28'd0, err_flags}, 32'd0);
      chk("clr_hs_frame_done", {31'd0, frame_done}, 32'd0);
      clear = 1'b0;
      s_axis.tvalid = 1'b0;
      s_axis.tkeep  = 4'hF;
      s_axis.tlast  = 1'b0;
      zero_model();
      send_frame(0, 3, 1'b0);
      send_frame(1, 5, 1'b1);
      check_stats("after_clear_hs");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
